// File: rtl/morse_decoder.sv
// Morse key decoder: times marks and spaces in units of DOT_CYCLES and emits
// the ASCII character (or word space) as a registered one-cycle strobe.
module morse_decoder #(
  parameter int unsigned DOT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       morse_in,
  output logic [7:0] decoded_data,
  output logic       decoded_data_strb,
  output logic       decode_error
);

  localparam int unsigned CNT_MAX_I = 8 * DOT_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX_I + 1);
  localparam int unsigned SYM_W     = 6;
  localparam int unsigned LEN_W     = 3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_I);
  localparam logic [CNT_W-1:0] DASH_TH = CNT_W'(2 * DOT_CYCLES);
  localparam logic [CNT_W-1:0] CHAR_TH = CNT_W'(3 * DOT_CYCLES);
  localparam logic [CNT_W-1:0] WORD_TH = CNT_W'(7 * DOT_CYCLES);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(SYM_W);

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QUERY = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [1:0]       live_q, live_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       data_q, data_d;
  logic             strb_q, strb_d;
  logic             err_q, err_d;

  logic             rise_c;
  logic             fall_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [8:0]       lookup_c;

  // ITU-R M.1677 table; symbols are first-sent-in-MSB, dot=0, dash=1.
  // Result is {error, ascii}.
  function automatic logic [8:0] lookup(input logic [LEN_W-1:0] len,
                                        input logic [SYM_W-1:0] sym);
    logic [8:0] r;
    r = {1'b1, ASCII_QUERY};
    case ({len, sym})
      {3'd1, 6'b000000}: r = {1'b0, 8'h45}; // E
      {3'd1, 6'b000001}: r = {1'b0, 8'h54}; // T
      {3'd2, 6'b000000}: r = {1'b0, 8'h49}; // I
      {3'd2, 6'b000001}: r = {1'b0, 8'h41}; // A
      {3'd2, 6'b000010}: r = {1'b0, 8'h4E}; // N
      {3'd2, 6'b000011}: r = {1'b0, 8'h4D}; // M
      {3'd3, 6'b000000}: r = {1'b0, 8'h53}; // S
      {3'd3, 6'b000001}: r = {1'b0, 8'h55}; // U
      {3'd3, 6'b000010}: r = {1'b0, 8'h52}; // R
      {3'd3, 6'b000011}: r = {1'b0, 8'h57}; // W
      {3'd3, 6'b000100}: r = {1'b0, 8'h44}; // D
      {3'd3, 6'b000101}: r = {1'b0, 8'h4B}; // K
      {3'd3, 6'b000110}: r = {1'b0, 8'h47}; // G
      {3'd3, 6'b000111}: r = {1'b0, 8'h4F}; // O
      {3'd4, 6'b000000}: r = {1'b0, 8'h48}; // H
      {3'd4, 6'b000001}: r = {1'b0, 8'h56}; // V
      {3'd4, 6'b000010}: r = {1'b0, 8'h46}; // F
      {3'd4, 6'b000100}: r = {1'b0, 8'h4C}; // L
      {3'd4, 6'b000110}: r = {1'b0, 8'h50}; // P
      {3'd4, 6'b000111}: r = {1'b0, 8'h4A}; // J
      {3'd4, 6'b001000}: r = {1'b0, 8'h42}; // B
      {3'd4, 6'b001001}: r = {1'b0, 8'h58}; // X
      {3'd4, 6'b001010}: r = {1'b0, 8'h43}; // C
      {3'd4, 6'b001011}: r = {1'b0, 8'h59}; // Y
      {3'd4, 6'b001100}: r = {1'b0, 8'h5A}; // Z
      {3'd4, 6'b001101}: r = {1'b0, 8'h51}; // Q
      {3'd5, 6'b011111}: r = {1'b0, 8'h30}; // 0
      {3'd5, 6'b001111}: r = {1'b0, 8'h31}; // 1
      {3'd5, 6'b000111}: r = {1'b0, 8'h32}; // 2
      {3'd5, 6'b000011}: r = {1'b0, 8'h33}; // 3
      {3'd5, 6'b000001}: r = {1'b0, 8'h34}; // 4
      {3'd5, 6'b000000}: r = {1'b0, 8'h35}; // 5
      {3'd5, 6'b010000}: r = {1'b0, 8'h36}; // 6
      {3'd5, 6'b011000}: r = {1'b0, 8'h37}; // 7
      {3'd5, 6'b011100}: r = {1'b0, 8'h38}; // 8
      {3'd5, 6'b011110}: r = {1'b0, 8'h39}; // 9
      default:           r = {1'b1, ASCII_QUERY};
    endcase
    return r;
  endfunction

  // Edge detection on the synchronized line; a rise only counts once the line
  // has been genuinely sampled low since reset, so a key held through reset is ignored.
  always_comb begin
    sync1_d   = morse_in;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    live_d    = {live_q[0], 1'b1};
    armed_d   = armed_q | (live_q[1] & ~sync2_q);
    rise_c    = sync2_q & ~prev_q & armed_q;
    fall_c    = ~sync2_q & prev_q;
    cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    lookup_c  = lookup(len_q, sym_q);
  end

  // Next-state, symbol buffer and emission logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    strb_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          cnt_d   = '0;
          state_d = MARK;
        end
      end

      MARK: begin
        if (fall_c) begin
          if (len_q == LEN_MAX) begin
            ovf_d = 1'b1;
          end else begin
            sym_d = {sym_q[SYM_W-2:0], (cnt_inc_c >= DASH_TH)};
            len_d = len_q + LEN_W'(1);
          end
          cnt_d   = '0;
          state_d = SPACE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      SPACE: begin
        if (rise_c) begin
          cnt_d   = '0;
          state_d = MARK;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CHAR_TH) begin
            data_d  = ovf_q ? ASCII_QUERY : lookup_c[7:0];
            err_d   = ovf_q | lookup_c[8];
            strb_d  = 1'b1;
            sym_d   = '0;
            len_d   = '0;
            ovf_d   = 1'b0;
            state_d = GAP;
          end
        end
      end

      GAP: begin
        if (rise_c) begin
          cnt_d   = '0;
          sym_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = MARK;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == WORD_TH) begin
            data_d  = ASCII_SPACE;
            strb_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      live_q  <= '0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      sym_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= 8'h00;
      strb_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      live_q  <= live_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
    end
  end

  assign decoded_data      = data_q;
  assign decoded_data_strb = strb_q;
  assign decode_error      = err_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with DOT_CYCLES=10; strobes are logged by a
// negedge monitor and each scenario task checks the log against hand-computed values.
module tb_morse_decoder;

  localparam int DOT = 10;

  logic       clk;
  logic       rst;
  logic       morse_in;
  logic [7:0] decoded_data;
  logic       decoded_data_strb;
  logic       decode_error;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       err;
  } ev_t;

  ev_t evq[$];
  ev_t mon_e;
  int  cyc;
  int  n_orphan;
  int  n_vec;
  int  n_err;
  int  fall_cyc;

  morse_decoder #(.DOT_CYCLES(DOT)) dut (
    .clk               (clk),
    .rst               (rst),
    .morse_in          (morse_in),
    .decoded_data      (decoded_data),
    .decoded_data_strb (decoded_data_strb),
    .decode_error      (decode_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (decoded_data_strb === 1'b1) begin
      mon_e.cyc  = cyc;
      mon_e.data = decoded_data;
      mon_e.err  = decode_error;
      evq.push_back(mon_e);
    end else if (decode_error !== 1'b0) begin
      n_orphan++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark(input int n);
    morse_in = 1'b1;
    step(n);
    morse_in = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic send_seq(input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      if (i > 0) step(DOT);
      mark((pat[i] == 8'h2D) ? 3 * DOT : DOT);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    morse_in = 1'b0;
    step(4);
    n_vec++; if (decoded_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", decoded_data); end
    n_vec++; if (decoded_data_strb !== 1'b0) begin n_err++; $display("FAIL reset_strb: got %b expected 0", decoded_data_strb); end
    n_vec++; if (decode_error !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", decode_error); end
    rst = 1'b0;
    step(4);
    evq.delete();
    n_orphan = 0;
  endtask

  task automatic test_letter_e;
    evq.delete();
    mark(DOT);
    step(40);
    n_vec++; if (evq.size() !== 1) begin n_err++; $display("FAIL e_count: got %0d expected 1", evq.size()); end
    if (evq.size() >= 1) begin
      n_vec++; if (evq[0].data !== 8'h45) begin n_err++; $display("FAIL e_data: got %h expected 45", evq[0].data); end
      n_vec++; if (evq[0].err !== 1'b0) begin n_err++; $display("FAIL e_err: got %b expected 0", evq[0].err); end
      n_vec++; if (evq[0].cyc !== fall_cyc + 33) begin n_err++; $display("FAIL e_latency: got cycle %0d expected %0d", evq[0].cyc, fall_cyc + 33); end
    end
    step(40);
    n_vec++; if (evq.size() !== 2) begin n_err++; $display("FAIL e_space_count: got %0d expected 2", evq.size()); end
    if (evq.size() >= 2) begin
      n_vec++; if (evq[1].data !== 8'h20) begin n_err++; $display("FAIL e_space_data: got %h expected 20", evq[1].data); end
      n_vec++; if (evq[1].cyc !== fall_cyc + 73) begin n_err++; $display("FAIL e_space_latency: got cycle %0d expected %0d", evq[1].cyc, fall_cyc + 73); end
    end
    step(5);
    n_vec++; if (decoded_data !== 8'h20) begin n_err++; $display("FAIL hold_data: got %h expected 20", decoded_data); end
    n_vec++; if (decoded_data_strb !== 1'b0) begin n_err++; $display("FAIL hold_strb: got %b expected 0", decoded_data_strb); end
  endtask

  task automatic test_letter_j;
    evq.delete();
    send_seq(".---");
    step(80);
    n_vec++; if (evq.size() !== 2) begin n_err++; $display("FAIL j_count: got %0d expected 2", evq.size()); end
    if (evq.size() >= 2) begin
      n_vec++; if (evq[0].data !== 8'h4A) begin n_err++; $display("FAIL j_data: got %h expected 4a", evq[0].data); end
      n_vec++; if (evq[0].err !== 1'b0) begin n_err++; $display("FAIL j_err: got %b expected 0", evq[0].err); end
      n_vec++; if (evq[1].data !== 8'h20) begin n_err++; $display("FAIL j_space: got %h expected 20", evq[1].data); end
      n_vec++; if (evq[1].cyc !== fall_cyc + 73) begin n_err++; $display("FAIL j_space_latency: got cycle %0d expected %0d", evq[1].cyc, fall_cyc + 73); end
    end
    step(150);
    n_vec++; if (evq.size() !== 2) begin n_err++; $display("FAIL j_idle_quiet: got %0d events expected 2", evq.size()); end
  endtask

  task automatic test_errors;
    string pats[2];
    pats[0] = "..--..";
    pats[1] = ".......";
    for (int p = 0; p < 2; p++) begin
      evq.delete();
      send_seq(pats[p]);
      step(80);
      n_vec++; if (evq.size() !== 2) begin n_err++; $display("FAIL err%0d_count: got %0d expected 2", p, evq.size()); end
      if (evq.size() >= 2) begin
        n_vec++; if (evq[0].data !== 8'h3F) begin n_err++; $display("FAIL err%0d_data: got %h expected 3f", p, evq[0].data); end
        n_vec++; if (evq[0].err !== 1'b1) begin n_err++; $display("FAIL err%0d_flag: got %b expected 1", p, evq[0].err); end
        n_vec++; if (evq[1].err !== 1'b0) begin n_err++; $display("FAIL err%0d_space_flag: got %b expected 0", p, evq[1].err); end
      end
    end
  endtask

  task automatic test_mark_len;
    int         lens[3];
    logic [7:0] exp[3];
    lens[0] = 19;  exp[0] = 8'h45;
    lens[1] = 20;  exp[1] = 8'h54;
    lens[2] = 200; exp[2] = 8'h54;
    for (int i = 0; i < 3; i++) begin
      evq.delete();
      mark(lens[i]);
      step(80);
      n_vec++; if (evq.size() !== 2) begin n_err++; $display("FAIL len%0d_count: got %0d expected 2", lens[i], evq.size()); end
      if (evq.size() >= 1) begin
        n_vec++; if (evq[0].data !== exp[i]) begin n_err++; $display("FAIL len%0d_data: got %h expected %h", lens[i], evq[0].data, exp[i]); end
      end
    end
  endtask

  task automatic test_charset;
    string      pats[8];
    logic [7:0] exp[8];
    pats[0] = ".....";  exp[0] = 8'h35;
    pats[1] = "-----";  exp[1] = 8'h30;
    pats[2] = ".----";  exp[2] = 8'h31;
    pats[3] = "--.-";   exp[3] = 8'h51;
    pats[4] = "--..";   exp[4] = 8'h5A;
    pats[5] = "-..-";   exp[5] = 8'h58;
    pats[6] = "...";    exp[6] = 8'h53;
    pats[7] = "---";    exp[7] = 8'h4F;
    for (int i = 0; i < 8; i++) begin
      evq.delete();
      send_seq(pats[i]);
      step(80);
      n_vec++; if (evq.size() !== 2) begin n_err++; $display("FAIL chr_%s_count: got %0d expected 2", pats[i], evq.size()); end
      if (evq.size() >= 1) begin
        n_vec++; if (evq[0].data !== exp[i] || evq[0].err !== 1'b0) begin n_err++; $display("FAIL chr_%s: got %h err %b expected %h err 0", pats[i], evq[0].data, evq[0].err, exp[i]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    evq.delete();
    mark(DOT);
    step(40);
    mark(3 * DOT);
    step(80);
    n_vec++; if (evq.size() !== 3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", evq.size()); end
    if (evq.size() >= 3) begin
      n_vec++; if (evq[0].data !== 8'h45) begin n_err++; $display("FAIL b2b_first: got %h expected 45", evq[0].data); end
      n_vec++; if (evq[1].data !== 8'h54) begin n_err++; $display("FAIL b2b_second: got %h expected 54", evq[1].data); end
      n_vec++; if (evq[1].cyc !== fall_cyc + 33) begin n_err++; $display("FAIL b2b_latency: got cycle %0d expected %0d", evq[1].cyc, fall_cyc + 33); end
      n_vec++; if (evq[2].data !== 8'h20) begin n_err++; $display("FAIL b2b_space: got %h expected 20", evq[2].data); end
    end
  endtask

  task automatic test_no_space_and_reset;
    evq.delete();
    send_seq(".-");
    step(50);
    morse_in = 1'b1;
    step(5);
    n_vec++; if (evq.size() !== 1) begin n_err++; $display("FAIL nospace_count: got %0d expected 1", evq.size()); end
    if (evq.size() >= 1) begin
      n_vec++; if (evq[0].data !== 8'h41) begin n_err++; $display("FAIL nospace_data: got %h expected 41", evq[0].data); end
    end
    rst = 1'b1;
    step(2);
    n_vec++; if (decoded_data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h expected 00", decoded_data); end
    n_vec++; if (decoded_data_strb !== 1'b0 || decode_error !== 1'b0) begin n_err++; $display("FAIL midrst_flags: got strb %b err %b expected 0 0", decoded_data_strb, decode_error); end
    rst = 1'b0;
    step(30);
    morse_in = 1'b0;
    step(100);
    n_vec++; if (evq.size() !== 1) begin n_err++; $display("FAIL held_line_quiet: got %0d events expected 1", evq.size()); end
    evq.delete();
    mark(DOT);
    step(80);
    n_vec++; if (evq.size() !== 2) begin n_err++; $display("FAIL post_rst_count: got %0d expected 2", evq.size()); end
    if (evq.size() >= 1) begin
      n_vec++; if (evq[0].data !== 8'h45) begin n_err++; $display("FAIL post_rst_data: got %h expected 45", evq[0].data); end
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    n_orphan = 0;
    fall_cyc = 0;
    rst      = 1'b1;
    morse_in = 1'b0;
    test_reset();
    test_letter_e();
    test_letter_j();
    test_errors();
    test_mark_len();
    test_charset();
    test_back_to_back();
    test_no_space_and_reset();
    n_vec++; if (n_orphan !== 0) begin n_err++; $display("FAIL orphan_error: got %0d error pulses without strobe expected 0", n_orphan); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 The block SHALL have one parameter: DOT_CYCLES, default 1000000, giving the clock cycles per Morse unit (dot length); legal range 4..2^20.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port morse_in, input, 1 bit: asynchronous Morse key line, high = mark (tone), low = space.
REQ-005 The block SHALL have port decoded_data, output, 8 bits: ASCII code of the last decoded character.
REQ-006 The block SHALL have port decoded_data_strb, output, 1 bit: one-cycle pulse, decoded_data valid in the same cycle.
REQ-007 The block SHALL have port decode_error, output, 1 bit: one-cycle pulse coincident with a strobe that carries 0x3F because of an unknown or over-long sequence.

Function
REQ-008 morse_in SHALL pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized value, giving 2 cycles of input latency.
REQ-009 The FSM SHALL have states IDLE, MARK, SPACE and GAP.
REQ-010 IDLE: wait for a synchronized rising edge (low->high), then clear the duration counter, enter MARK; a level held high without a rising edge SHALL be ignored.
REQ-011 MARK: count cycles; on falling edge classify count < 2*DOT_CYCLES as dot (0), else dash (1), append symbol, clear counter, enter SPACE.
REQ-012 The duration counter SHALL saturate at 8*DOT_CYCLES, with width ceil(log2(8*DOT_CYCLES+1)); a saturated mark SHALL be a dash.
REQ-013 SPACE: rising edge before the count reaches 3*DOT_CYCLES is an intra-character gap (clear counter, enter MARK).
REQ-014 SPACE: when the count reaches 3*DOT_CYCLES, emit the character (REQ-017), keep counting, and enter GAP.
REQ-015 GAP: rising edge before the count reaches 7*DOT_CYCLES enters MARK with the symbol buffer cleared and no space emitted.
REQ-016 GAP: when the count reaches 7*DOT_CYCLES, emit 0x20 (word space) once and enter IDLE.
REQ-017 Emission SHALL register decoded_data and pulse decoded_data_strb high for exactly one cycle, in the cycle after the threshold count is reached; the symbol buffer SHALL clear in that same cycle.
REQ-018 The symbol buffer SHALL hold up to 6 symbols plus a 3-bit length.
REQ-019 Supported sequences SHALL be A-Z (uppercase ASCII 0x41-0x5A) and 0-9 (0x30-0x39) per ITU-R M.1677.
REQ-020 Lookup SHALL be combinational on {length, symbols}.
REQ-021 Any other sequence of length 1..6 SHALL emit 0x3F with decode_error.
REQ-022 A 7th symbol SHALL set an overflow flag and further symbols are discarded; the character then SHALL emit 0x3F with decode_error.
REQ-023 decoded_data SHALL hold its last value between strobes.
REQ-024 A falling and a rising edge cannot coincide after synchronization; a mark shorter than 1 cycle post-sync is impossible, and a 1-cycle mark SHALL be a dot.

Reset
REQ-025 While rst is high at a clock edge: FSM->IDLE, counter=0, symbol buffer, length and overflow flag cleared, synchronizer flops=0, decoded_data=0x00, decoded_data_strb=0, decode_error=0.
REQ-026 Reset asserted mid-mark or mid-space SHALL discard the partial character with no strobe.
REQ-027 After reset, a line already high SHALL not start a mark until it has fallen and risen again.

Verification (DOT_CYCLES=10)
REQ-028 Mark 10 cycles, then low 40 cycles -> one strobe, decoded_data=0x45 'E', decode_error=0, strobe 31 cycles after the synchronized falling edge.
REQ-029 Dot, gap 10, dash (30), gap 10, dash, gap 10, dash (as 'J' = .---), then low >=70 cycles -> strobe 0x4A, then exactly one strobe 0x20 at count 70, FSM in IDLE.
REQ-030 Sequence ..--.. (6 symbols, unassigned) -> strobe 0x3F with decode_error=1; 7 dots -> 0x3F with decode_error=1.
REQ-031 Marks of 19 and 20 cycles -> dot ('E' 0x45) and dash ('T' 0x54) respectively; mark of 200 cycles -> dash, 'T'.
REQ-032 'A' (.-) then low 40 cycles then new mark at count 50 -> strobe 0x41, no 0x20 strobe; rst pulsed mid-mark of next letter -> no strobe, outputs reset values.
